grf_wb_arbiter: RTL and testbench

Write-back arbiter driving the general register file's single write port. Merges in-order write requests from the main pipeline with out-of-order results from the multi-cycle multiply/divide unit. MD results are buffered in a small FIFO and drained into idle write slots; a starvation guard stalls the pipeline when a queued result has waited too long. It sits between the write-back stage, the MD unit and the register file, and exports a pending-register mask to the hazard unit.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/grf_wb_arbiter_if.sv | 47 ++++
 rtl/wb_fifo.sv | 66 ++++++
 rtl/grf_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
package wb_pkg;

    localparam int DEPTH_DEF        = 4;
    localparam int STARVE_LIMIT_DEF = 8;
    localparam int DATA_W           = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [4:0]        a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_req_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_FIFO = 2'd2
    } sel_e;

    // One-hot register mask; $0 never marks anything.
    function automatic logic [31:0] reg_mask(input logic [4:0] r);
        logic [31:0] m;
        m = 32'd0;
        if (r != ZERO_REG) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_if.sv
// Pipeline, MD-unit and register-file write-port bundle around the write-back arbiter.
interface grf_wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        pipe_accept;

    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_a3;
    logic [31:0] md_wd;
    logic [31:0] md_pc;

    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    logic          stall_req;
    logic [31:0]   pending;
    logic [CW-1:0] count;

    modport master (
        input  pipe_we, pipe_a3, pipe_wd, pipe_pc,
        input  md_valid, md_a3, md_wd, md_pc,
        output pipe_accept, md_ready,
        output grf_we, grf_a3, grf_wd, grf_pc,
        output stall_req, pending, count
    );

    modport slave (
        output pipe_we, pipe_a3, pipe_wd, pipe_pc,
        output md_valid, md_a3, md_wd, md_pc,
        input  pipe_accept, md_ready,
        input  grf_we, grf_a3, grf_wd, grf_pc,
        input  stall_req, pending, count
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of write-back requests, exposing every slot and its validity.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  wb_req_t                    din,
    output wb_req_t                    dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           entry_vld,
    output wb_req_t [DEPTH-1:0]        entries
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    wb_req_t [DEPTH-1:0] mem;
    logic do_push;
    logic do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; validity comes solely from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [AW-1:0] off;
        assign off          = AW'(i) - rd_ptr;
        assign entry_vld[i] = ({1'b0, off} < cnt);
    end

    assign dout    = mem[rd_ptr];
    assign count   = cnt;
    assign entries = mem;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writes plus buffered MD results with a starvation guard.
module grf_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    grf_wb_arbiter_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    wb_req_t               head;
    wb_req_t               md_req;
    wb_req_t [DEPTH-1:0]   entries;
    logic [DEPTH-1:0]      entry_vld;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         cnt;

    logic [WW-1:0] wait_cnt;
    logic          stall;
    logic          pipe_vld;
    logic          push;
    logic          pop;
    sel_e          sel;
    logic [31:0]   pend;

    logic          grf_we_p1;
    logic [4:0]    grf_a3_p1;
    logic [31:0]   grf_wd_p1;
    logic [31:0]   grf_pc_p1;

    assign md_req = '{a3: bus.md_a3, wd: bus.md_wd, pc: bus.md_pc};

    // A handshake to $0 completes but the result is dropped here.
    assign push = bus.md_valid && !full && (bus.md_a3 != ZERO_REG);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       (md_req),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .count     (cnt),
        .entry_vld (entry_vld),
        .entries   (entries)
    );

    assign pipe_vld = bus.pipe_we && (bus.pipe_a3 != ZERO_REG);
    assign stall    = (wait_cnt == WW'(STARVE_LIMIT)) && !empty;

    always_comb begin
        sel = SEL_NONE;
        if (stall && !empty)   sel = SEL_FIFO;
        else if (pipe_vld)     sel = SEL_PIPE;
        else if (!empty)       sel = SEL_FIFO;
    end

    assign pop = (sel == SEL_FIFO);

    always_comb begin
        pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) pend = pend | reg_mask(entries[i].a3);
        end
        pend[0] = 1'b0;
    end

    // Head age: restarts on every pop and while nothing is queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (pop || empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(STARVE_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // ---- stage p1: registered write port ----
    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we_p1 <= 1'b0;
            grf_a3_p1 <= '0;
            grf_wd_p1 <= '0;
            grf_pc_p1 <= '0;
        end else begin
            grf_we_p1 <= (sel != SEL_NONE);
            case (sel)
                SEL_PIPE: begin
                    grf_a3_p1 <= bus.pipe_a3;
                    grf_wd_p1 <= bus.pipe_wd;
                    grf_pc_p1 <= bus.pipe_pc;
                end
                SEL_FIFO: begin
                    grf_a3_p1 <= head.a3;
                    grf_wd_p1 <= head.wd;
                    grf_pc_p1 <= head.pc;
                end
                default: begin
                    grf_a3_p1 <= grf_a3_p1;
                    grf_wd_p1 <= grf_wd_p1;
                    grf_pc_p1 <= grf_pc_p1;
                end
            endcase
        end
    end

    assign bus.pipe_accept = !stall;
    assign bus.stall_req   = stall;
    assign bus.md_ready    = !full;
    assign bus.count       = cnt;
    assign bus.pending     = pend;
    assign bus.grf_we      = grf_we_p1;
    assign bus.grf_a3      = grf_a3_p1;
    assign bus.grf_wd      = grf_wd_p1;
    assign bus.grf_pc      = grf_pc_p1;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed and randomized bench for grf_wb_arbiter against a queue-based reference model.
module tb_grf_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    grf_wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_req_t mq[$];
    wb_req_t src[$];
    int      wcnt;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [31:0] e_pc;
    bit      e_known;
    bit      last_acc;
    bit      dut_stall_seen;
    int      vectors = 0;
    int      miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [31:0] m_pend;
        bit m_stall, m_ready, pv, popped;
        int sz0;
        wb_req_t h;
        if (src.size() > 0) begin
            bus.md_valid = 1'b1;
            bus.md_a3 = src[0].a3;
            bus.md_wd = src[0].wd;
            bus.md_pc = src[0].pc;
        end else begin
            bus.md_valid = 1'b0;
            bus.md_a3 = 5'd0;
            bus.md_wd = 32'd0;
            bus.md_pc = 32'd0;
        end
        #1;
        sz0 = mq.size();
        m_pend = 32'd0;
        foreach (mq[i]) if (mq[i].a3 != 5'd0) m_pend[mq[i].a3] = 1'b1;
        m_stall = (wcnt == LIMIT) && (sz0 != 0);
        m_ready = (sz0 != DEPTH);
        chk("stall_req", bus.stall_req, m_stall);
        chk("pipe_accept", bus.pipe_accept, !m_stall);
        chk("md_ready", bus.md_ready, m_ready);
        chk("pending", bus.pending, m_pend);
        chk("count", bus.count, sz0);
        chk("grf_we", bus.grf_we, e_we);
        if (e_known) begin
            chk("grf_a3", bus.grf_a3, e_a3);
            chk("grf_wd", bus.grf_wd, e_wd);
            chk("grf_pc", bus.grf_pc, e_pc);
        end
        if (bus.grf_we) chk("grf_a3_nonzero", bus.grf_a3 != 5'd0, 1);
        pv = bus.pipe_we && (bus.pipe_a3 != 5'd0);
        if (pv) chk("waw_precondition", m_pend[bus.pipe_a3], 0);
        if (bus.stall_req) dut_stall_seen = 1'b1;
        popped = 1'b0;
        if (sz0 > 0 && (m_stall || !pv)) begin
            h = mq.pop_front();
            e_we = 1'b1; e_a3 = h.a3; e_wd = h.wd; e_pc = h.pc;
            e_known = 1'b1;
            popped = 1'b1;
        end else if (pv) begin
            e_we = 1'b1; e_a3 = bus.pipe_a3; e_wd = bus.pipe_wd; e_pc = bus.pipe_pc;
            e_known = 1'b1;
        end else begin
            if (e_we) e_known = 1'b0;
            e_we = 1'b0;
        end
        if (src.size() > 0 && m_ready) begin
            h = src.pop_front();
            if (h.a3 != 5'd0) mq.push_back(h);
        end
        if (popped || sz0 == 0) wcnt = 0;
        else if (wcnt < LIMIT) wcnt++;
        last_acc = !m_stall;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.pipe_we = 1'b0; bus.pipe_a3 = 5'd0; bus.pipe_wd = 32'd0; bus.pipe_pc = 32'd0;
        bus.md_valid = 1'b0; bus.md_a3 = 5'd0; bus.md_wd = 32'd0; bus.md_pc = 32'd0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        src.delete();
        wcnt = 0;
        e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
        e_known = 1'b1;
    endtask

    task automatic pipe_issue(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        bus.pipe_we = 1'b1; bus.pipe_a3 = a3; bus.pipe_wd = wd; bus.pipe_pc = pc;
        for (int t = 0; t < 64; t++) begin
            step();
            if (last_acc) return;
        end
        chk("pipe_accept_bound", last_acc, 1);
    endtask

    task automatic md_send(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        wb_req_t r;
        r.a3 = a3; r.wd = wd; r.pc = pc;
        src.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        repeat (3) step();

        pipe_issue(5'd5, 32'h1234_5678, 32'h0000_3000);
        bus.pipe_we = 1'b0;
        step();
        step();

        dut_stall_seen = 1'b0;
        md_send(5'd8, 32'hAAAA_0001, 32'h0000_4000);
        for (int i = 0; i < 14; i++) pipe_issue(5'd9, $urandom, 32'h0000_5000 + 32'(i * 4));
        bus.pipe_we = 1'b0;
        step();
        chk("starve_stall_seen", dut_stall_seen, 1);
        step();

        for (int i = 0; i < 5; i++) md_send(5'(16 + i), $urandom, 32'h0000_6000 + 32'(i * 4));
        repeat (10) step();

        for (int i = 0; i < 5; i++) md_send(5'(21 + i), $urandom, 32'h0000_7000 + 32'(i * 4));
        for (int i = 0; i < 20; i++) pipe_issue(5'(1 + (i % 15)), $urandom, 32'h0000_8000 + 32'(i * 4));
        bus.pipe_we = 1'b0;
        repeat (12) step();

        md_send(5'd17, 32'hC0DE_0017, 32'h0000_9000);
        pipe_issue(5'd0, 32'hDEAD_0000, 32'h0000_9100);
        pipe_issue(5'd0, 32'hDEAD_0001, 32'h0000_9104);
        bus.pipe_we = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 3; i++) md_send(5'(26 + i), $urandom, 32'h0000_A000 + 32'(i * 4));
        pipe_issue(5'd3, $urandom, 32'h0000_B000);
        pipe_issue(5'd4, $urandom, 32'h0000_B004);
        pipe_issue(5'd5, $urandom, 32'h0000_B008);
        chk("queued_before_reset", bus.count, 3);
        do_reset();
        repeat (4) step();

        for (int c = 0; c < 400; c++) begin
            if (src.size() < 3 && $urandom_range(0, 2) == 0)
                md_send(($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(16, 31)),
                        $urandom, $urandom);
            if (!bus.pipe_we || last_acc) begin
                if ($urandom_range(0, 9) < 6) begin
                    bus.pipe_we = 1'b1;
                    bus.pipe_a3 = 5'($urandom_range(0, 15));
                    bus.pipe_wd = $urandom;
                    bus.pipe_pc = $urandom;
                end else begin
                    bus.pipe_we = 1'b0;
                end
            end
            step();
        end
        bus.pipe_we = 1'b0;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
